// File: rtl/itch_pkg.sv
// -----------------------------------------------------------------------------
// itch_pkg
// Constants and types shared by the ITCH message encoders and payload
// decoders. Byte offsets are counted from the message type byte (offset 0),
// not from the optional length prefix.
// -----------------------------------------------------------------------------
package itch_pkg;

    // Cancel Order ('X') message layout
    localparam logic [7:0] MSG_TYPE_CANCEL   = 8'h58;
    localparam int         CANCEL_MSG_LEN    = 13;
    localparam int         CANCEL_REF_OFS    = 1;
    localparam int         CANCEL_SHARES_OFS = 9;

    // Optional 16-bit big-endian length that precedes a message on the wire
    localparam int         LEN_PREFIX_BYTES  = 2;

    // Byte serializer control states
    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_e;

    // Total number of bytes on the wire for one Cancel Order message
    function automatic int cancel_wire_len(input bit with_prefix);
        return CANCEL_MSG_LEN + (with_prefix ? LEN_PREFIX_BYTES : 0);
    endfunction

endpackage

// File: rtl/cancel_order_encoder_if.sv
// -----------------------------------------------------------------------------
// cancel_order_encoder_if
// Field-set input handshake plus byte-stream output handshake of the Cancel
// Order encoder.
//   in_valid / in_ready        : field set offered / accepted
//   in_order_ref[63:0]         : order reference number
//   in_cancel_shares[31:0]     : shares cancelled
//   out_valid / out_ready      : byte offered / accepted
//   out_data[7:0]              : current message byte
//   out_sof / out_eof          : first / last byte of a message
// The encoder uses the slave modport; the field source and byte sink side
// uses the master modport.
// -----------------------------------------------------------------------------
interface cancel_order_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_order_ref;
    logic [31:0] in_cancel_shares;

    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;

    modport slave (
        input  in_valid,
        input  in_order_ref,
        input  in_cancel_shares,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sof,
        output out_eof
    );

    modport master (
        output in_valid,
        output in_order_ref,
        output in_cancel_shares,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sof,
        input  out_eof
    );

endinterface

// File: rtl/itch_byte_serializer.sv
// -----------------------------------------------------------------------------
// itch_byte_serializer
// Generic N-byte message serializer. A whole message is loaded as one wide
// word (byte 0 in the most significant position) and then streamed out one
// byte per valid/ready transfer with start/end-of-message flags. A new word
// can be loaded on the same cycle the last byte transfers, so consecutive
// messages stream with no idle cycle between them.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   load_valid / load_ready : word offered / accepted
//   load_data[NBYTES*8-1:0] : message word, byte 0 in bits [NBYTES*8-1 -: 8]
//   out_valid / out_ready   : byte offered / accepted
//   out_data[7:0]           : byte at the current index
//   out_sof / out_eof       : index is first / last byte
//   busy                    : a message is loaded and not fully sent
// -----------------------------------------------------------------------------
module itch_byte_serializer
    import itch_pkg::*;
#(
    parameter int NBYTES = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [NBYTES*8-1:0]   load_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic                  busy
);

    localparam int                IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

    ser_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NBYTES*8-1:0]  word_q;
    logic                 load;
    logic                 xfer;
    logic                 at_last;

    assign at_last = (idx_q == LAST_IDX);

    // State, index and message word registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SER_IDLE;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load) begin
                word_q <= load_data;
            end
        end
    end

    // Next-state, index advance and handshake decode
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        load_ready = 1'b0;
        xfer       = 1'b0;

        case (state_q)
            SER_IDLE: begin
                // Held low while reset is asserted so nothing is accepted
                load_ready = rst_n;
            end
            SER_SEND: begin
                xfer       = out_ready;
                // A new word may replace the message as its last byte leaves
                load_ready = rst_n && out_ready && at_last;
            end
            default: begin
                state_d = SER_IDLE;
            end
        endcase

        load = load_valid && load_ready;

        if (xfer) begin
            if (at_last) begin
                state_d = SER_IDLE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (load) begin
            state_d = SER_SEND;
            idx_d   = '0;
        end
    end

    // Byte select: byte i of the message sits at word bits [(NBYTES-1-i)*8 +: 8]
    always_comb begin
        out_data = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                out_data = word_q[(NBYTES-1-i)*8 +: 8];
            end
        end
    end

    assign out_valid = (state_q == SER_SEND);
    assign out_sof   = out_valid && (idx_q == '0);
    assign out_eof   = out_valid && at_last;
    assign busy      = out_valid;

endmodule

// File: rtl/cancel_order_encoder.sv
// -----------------------------------------------------------------------------
// cancel_order_encoder
// Builds ITCH Cancel Order ('X') messages from an order reference and a
// share count and streams them out one byte per handshake:
//   [0x00 0x0D]  type  ref[63:56] .. ref[7:0]  shares[31:24] .. shares[7:0]
// The bracketed 2-byte big-endian length is emitted only when
// EMIT_LEN_PREFIX is set. Field values are passed through unmodified.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus            : field-set input and byte-stream output (slave side)
//   busy           : a message is loaded and not fully sent
//   msg_count[31:0]: number of messages whose last byte has transferred
//                    (wraps at 2^32)
// -----------------------------------------------------------------------------
module cancel_order_encoder
    import itch_pkg::*;
#(
    parameter bit         EMIT_LEN_PREFIX = 1'b0,
    parameter logic [7:0] MSG_TYPE        = MSG_TYPE_CANCEL
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cancel_order_encoder_if.slave   bus,
    output logic                    busy,
    output logic [31:0]             msg_count
);

    localparam int          PFX       = EMIT_LEN_PREFIX ? LEN_PREFIX_BYTES : 0;
    localparam int          NBYTES    = cancel_wire_len(EMIT_LEN_PREFIX);
    localparam logic [15:0] LEN_FIELD = 16'(CANCEL_MSG_LEN);

    logic [7:0]           frame [NBYTES];
    logic [NBYTES*8-1:0]  frame_word;
    logic [31:0]          msg_count_q;

    // Field packing: message offsets are shifted by the prefix length
    always_comb begin
        for (int i = 0; i < NBYTES; i++) begin
            frame[i] = 8'h00;
        end
        frame_word = '0;

        if (EMIT_LEN_PREFIX) begin
            frame[0] = LEN_FIELD[15:8];
            frame[1] = LEN_FIELD[7:0];
        end

        frame[PFX] = MSG_TYPE;

        for (int i = 0; i < 8; i++) begin
            frame[PFX + CANCEL_REF_OFS + i] = bus.in_order_ref[63 - 8*i -: 8];
        end

        for (int i = 0; i < 4; i++) begin
            frame[PFX + CANCEL_SHARES_OFS + i] = bus.in_cancel_shares[31 - 8*i -: 8];
        end

        for (int i = 0; i < NBYTES; i++) begin
            frame_word[(NBYTES-1-i)*8 +: 8] = frame[i];
        end
    end

    // Serializer owns field capture, byte index, and all stream flags
    itch_byte_serializer #(
        .NBYTES (NBYTES)
    ) u_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (bus.in_valid),
        .load_ready (bus.in_ready),
        .load_data  (frame_word),
        .out_valid  (bus.out_valid),
        .out_ready  (bus.out_ready),
        .out_data   (bus.out_data),
        .out_sof    (bus.out_sof),
        .out_eof    (bus.out_eof),
        .busy       (busy)
    );

    // Completed-message counter; an abandoned message never reaches eof
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_count_q <= '0;
        end else if (bus.out_valid && bus.out_ready && bus.out_eof) begin
            msg_count_q <= msg_count_q + 32'd1;
        end
    end

    assign msg_count = msg_count_q;

endmodule

// File: tb/tb_cancel_order_encoder.sv
// -----------------------------------------------------------------------------
// tb_cancel_order_encoder
// Directed bench for cancel_order_encoder: one instance without and one with
// the length prefix, sharing clock and reset. Transfers are recorded on the
// falling edge and compared against hand-written byte sequences.
// -----------------------------------------------------------------------------
module tb_cancel_order_encoder;

    logic        clk;
    logic        rst_n;
    logic        busy0, busy1;
    logic [31:0] cnt0, cnt1;

    cancel_order_encoder_if bus0 ();
    cancel_order_encoder_if bus1 ();

    cancel_order_encoder #(.EMIT_LEN_PREFIX(1'b0)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus0),
        .busy      (busy0),
        .msg_count (cnt0)
    );

    cancel_order_encoder #(.EMIT_LEN_PREFIX(1'b1)) u_dut_pfx (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1),
        .busy      (busy1),
        .msg_count (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got0_d[$];
    logic       got0_s[$];
    logic       got0_e[$];
    int         got0_c[$];
    logic [7:0] got1_d[$];
    logic       got1_s[$];
    logic       got1_e[$];
    logic [7:0] exp_q[$];

    // Transfer monitors: a byte valid and ready at the falling edge moves on
    // the following rising edge
    always @(negedge clk) begin
        if (bus0.out_valid && bus0.out_ready) begin
            got0_d.push_back(bus0.out_data);
            got0_s.push_back(bus0.out_sof);
            got0_e.push_back(bus0.out_eof);
            got0_c.push_back(cyc);
        end
        if (bus1.out_valid && bus1.out_ready) begin
            got1_d.push_back(bus1.out_data);
            got1_s.push_back(bus1.out_sof);
            got1_e.push_back(bus1.out_eof);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        got0_d.delete(); got0_s.delete(); got0_e.delete(); got0_c.delete();
        got1_d.delete(); got1_s.delete(); got1_e.delete();
    endtask

    task automatic wait_accept(input int sel, input string tag);
        int n = 0;
        if (sel == 0) begin
            while (!(bus0.in_valid && bus0.in_ready) && n < 40) begin tick(); n++; end
        end else begin
            while (!(bus1.in_valid && bus1.in_ready) && n < 40) begin tick(); n++; end
        end
        if (n >= 40) check({tag, "_accept_timeout"}, 64'd1, 64'd0);
        tick();
    endtask

    task automatic wait_bytes(input int sel, input int nb, input string tag);
        int k = 0;
        while (((sel == 0) ? got0_d.size() : got1_d.size()) < nb && k < 120) begin
            tick();
            k++;
        end
        if (k >= 120) check({tag, "_bytes_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic check_stream(input int sel, input string tag, input int msg_len);
        logic [7:0] d[$];
        logic       s[$];
        logic       e[$];
        if (sel == 0) begin d = got0_d; s = got0_s; e = got0_e; end
        else          begin d = got1_d; s = got1_s; e = got1_e; end
        check({tag, "_len"}, 64'(d.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < d.size()) begin
                check($sformatf("%s_b%0d", tag, i),
                      64'({s[i], e[i], d[i]}),
                      64'({(i % msg_len) == 0, (i % msg_len) == (msg_len - 1), exp_q[i]}));
            end
        end
    endtask

    task automatic load0(input logic [63:0] r, input logic [31:0] sh);
        bus0.in_order_ref     = r;
        bus0.in_cancel_shares = sh;
        bus0.in_valid         = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0] pat;
        logic [9:0] prev;
        logic       stalled;
        int         k;

        rst_n                 = 1'b0;
        bus0.in_valid         = 1'b0;
        bus0.in_order_ref     = '0;
        bus0.in_cancel_shares = '0;
        bus0.out_ready        = 1'b1;
        bus1.in_valid         = 1'b0;
        bus1.in_order_ref     = '0;
        bus1.in_cancel_shares = '0;
        bus1.out_ready        = 1'b1;

        // Reset state
        tick();
        check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus0.in_ready),  64'd0);
        check("rst_flags",     64'({bus0.out_sof, bus0.out_eof}), 64'd0);
        check("rst_out_data",  64'(bus0.out_data),  64'h00);
        check("rst_busy",      64'(busy0),          64'd0);
        check("rst_msg_count", 64'(cnt0),           64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single message, no prefix, sink always ready
        clear_q();
        exp_q = '{8'h58, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                  8'h0A, 8'h0B, 8'h0C, 8'h0D};
        load0(64'h0102030405060708, 32'h0A0B0C0D);
        check("t1_in_ready_idle", 64'(bus0.in_ready), 64'd1);
        wait_accept(0, "t1");
        bus0.in_valid         = 1'b0;
        bus0.in_order_ref     = 64'hDEADBEEFDEADBEEF;
        bus0.in_cancel_shares = 32'hCAFEF00D;
        check("t1_first_byte", 64'({bus0.out_valid, bus0.out_sof, bus0.out_data}), 64'({1'b1, 1'b1, 8'h58}));
        check("t1_busy", 64'(busy0), 64'd1);
        wait_bytes(0, 13, "t1");
        check_stream(0, "t1", 13);
        check("t1_msg_count", 64'(cnt0), 64'd1);
        check("t1_idle_after", 64'({bus0.out_valid, busy0}), 64'd0);

        // Backpressure with out_ready pattern 1,0,0,1,...
        clear_q();
        load0(64'h0102030405060708, 32'h0A0B0C0D);
        wait_accept(0, "bp");
        bus0.in_valid = 1'b0;
        pat     = 4'b1001;
        stalled = 1'b0;
        prev    = '0;
        k       = 0;
        while (k < 80) begin
            bus0.out_ready = pat[k % 4];
            if (stalled) check($sformatf("bp_stable_%0d", k),
                               64'({bus0.out_sof, bus0.out_eof, bus0.out_data}), 64'(prev));
            check($sformatf("bp_valid_%0d", k), 64'(bus0.out_valid), 64'd1);
            if (!(bus0.out_ready && bus0.out_eof))
                check($sformatf("bp_in_ready_%0d", k), 64'(bus0.in_ready), 64'd0);
            prev    = {bus0.out_sof, bus0.out_eof, bus0.out_data};
            stalled = !bus0.out_ready;
            if (bus0.out_ready && bus0.out_eof) begin
                tick();
                break;
            end
            tick();
            k++;
        end
        if (k >= 80) check("bp_timeout", 64'd1, 64'd0);
        bus0.out_ready = 1'b1;
        check_stream(0, "bp", 13);
        check("bp_msg_count", 64'(cnt0), 64'd2);

        // Back-to-back messages after a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("b2b_count_cleared", 64'(cnt0), 64'd0);
        clear_q();
        exp_q = '{8'h58, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                  8'h00, 8'h00, 8'h00, 8'h64,
                  8'h58, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
                  8'h00, 8'h00, 8'h00, 8'hC8};
        load0(64'd1, 32'd100);
        wait_accept(0, "b2b_a");
        load0(64'd2, 32'd200);
        wait_accept(0, "b2b_b");
        bus0.in_valid         = 1'b0;
        bus0.in_order_ref     = '1;
        bus0.in_cancel_shares = '1;
        wait_bytes(0, 26, "b2b");
        check_stream(0, "b2b", 13);
        if (got0_c.size() >= 26) begin
            check("b2b_no_bubble_eof_sof", 64'(got0_c[13] - got0_c[12]), 64'd1);
            check("b2b_span", 64'(got0_c[25] - got0_c[0]), 64'd25);
        end
        check("b2b_msg_count", 64'(cnt0), 64'd2);

        // Length prefix instance
        clear_q();
        exp_q = '{8'h00, 8'h0D, 8'h58, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                  8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        bus1.in_order_ref     = 64'hFFFFFFFFFFFFFFFF;
        bus1.in_cancel_shares = 32'd0;
        bus1.in_valid         = 1'b1;
        wait_accept(1, "pfx");
        bus1.in_valid = 1'b0;
        wait_bytes(1, 15, "pfx");
        check_stream(1, "pfx", 15);
        check("pfx_msg_count", 64'(cnt1), 64'd1);

        // Reset in the middle of a message
        clear_q();
        load0(64'h0102030405060708, 32'h0A0B0C0D);
        wait_accept(0, "rm");
        bus0.in_valid = 1'b0;
        wait_bytes(0, 5, "rm");
        rst_n = 1'b0;
        #1;
        check("rm_out_valid", 64'(bus0.out_valid), 64'd0);
        check("rm_flags_data", 64'({bus0.out_sof, bus0.out_eof, bus0.out_data}), 64'd0);
        check("rm_busy_ready", 64'({busy0, bus0.in_ready}), 64'd0);
        check("rm_msg_count", 64'(cnt0), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("rm_idle_after_release", 64'({bus0.out_valid, busy0}), 64'd0);
        clear_q();
        exp_q = '{8'h58, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                  8'h0A, 8'h0B, 8'h0C, 8'h0D};
        load0(64'h0102030405060708, 32'h0A0B0C0D);
        wait_accept(0, "rm2");
        bus0.in_valid = 1'b0;
        wait_bytes(0, 13, "rm2");
        check_stream(0, "rm2", 13);
        check("rm2_msg_count", 64'(cnt0), 64'd1);

        // Counter wrap
        force u_dut.msg_count_q = 32'hFFFFFFFF;
        tick();
        release u_dut.msg_count_q;
        tick();
        check("wrap_preset", 64'(cnt0), 64'hFFFFFFFF);
        clear_q();
        load0(64'h0, 32'h0);
        wait_accept(0, "wrap");
        bus0.in_valid = 1'b0;
        wait_bytes(0, 13, "wrap");
        check("wrap_msg_count", 64'(cnt0), 64'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
